sysarray_tile_feeder: RTL and testbench

SYSARRAY_TILE_FEEDER -- requirements
Module: sysarray_tile_feeder

---
 rtl/sysarray_pkg.sv | 6 +
 rtl/sat_accum.sv | 24 ++
 rtl/sysarray_tile_feeder.sv | 161 ++++++++++++++++
 tb/tb_sysarray_tile_feeder.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/sysarray_pkg.sv
// sysarray_pkg: shared FSM states and limits for the systolic tile feeder
package sysarray_pkg;
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, RUN, GAP, ACCUM, OUT} state_e;
    localparam int MAX_CHUNKS_DEF = 16;
    localparam int RUN_TIMEOUT    = 8;
endpackage

// File: rtl/sat_accum.sv
// sat_accum: wide signed accumulator with a saturated IW-bit view
module sat_accum #(
    parameter int IW = 16,
    parameter int AW = 21
) (
    input  logic          clk,
    input  logic          _reset,
    input  logic          clr,
    input  logic          add_en,
    input  logic [IW-1:0] addend,
    output logic [IW-1:0] sat_out
);
    logic [AW-1:0] acc_q, acc_d;
    logic [AW-IW:0] top;
    // clear on job start, add one sign-extended chunk result per ACCUM cycle
    always_comb acc_d = clr ? '0 : add_en ? acc_q + {{(AW-IW){addend[IW-1]}}, addend} : acc_q;
    // accumulator register
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) acc_q <= '0;
        else         acc_q <= acc_d;
    end
    assign top     = acc_q[AW-1:IW-1];
    assign sat_out = (&top || ~|top) ? acc_q[IW-1:0] : {acc_q[AW-1], {(IW-1){~acc_q[AW-1]}}};
endmodule

// File: rtl/sysarray_tile_feeder.sv
// sysarray_tile_feeder: streams K-chunks into a 2x2x4 mini array and accumulates the tile (option: SYSARRAY_FEEDER_IMPORTANCE_EN)
module sysarray_tile_feeder import sysarray_pkg::*; #(
    parameter int WIDTH      = 8,
    parameter int MAX_CHUNKS = MAX_CHUNKS_DEF,
    localparam int CW        = $clog2(MAX_CHUNKS + 1),
    localparam int AW        = $clog2(MAX_CHUNKS)
) (
    input  logic                 clk,
    input  logic                 _reset,
    input  logic                 start,
    input  logic [CW-1:0]        num_chunks,
    output logic                 rd_en,
    output logic [AW-1:0]        rd_addr,
    input  logic [8*WIDTH-1:0]   a_rd_data,
    input  logic [8*WIDTH-1:0]   b_rd_data,
    output logic [WIDTH-1:0]     arr_a00, arr_a01, arr_a02, arr_a03,
    output logic [WIDTH-1:0]     arr_a10, arr_a11, arr_a12, arr_a13,
    output logic [WIDTH-1:0]     arr_b00, arr_b01, arr_b10, arr_b11,
    output logic [WIDTH-1:0]     arr_b20, arr_b21, arr_b30, arr_b31,
    output logic                 arr_enable,
    output logic                 arr_cal_importance,
    input  logic                 arr_done,
    input  logic [2*WIDTH-1:0]   arr_result0, arr_result1, arr_result2, arr_result3,
    input  logic [2*WIDTH-1:0]   arr_importance,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_c00, out_c01, out_c10, out_c11,
    output logic                 busy,
    output logic                 err
`ifdef SYSARRAY_FEEDER_IMPORTANCE_EN
    , output logic [2*WIDTH-1:0] out_importance
`endif
);
    localparam int RW   = 2 * WIDTH;
    localparam int ACCW = RW + $clog2(MAX_CHUNKS) + 1;
    localparam int TW   = $clog2(RUN_TIMEOUT);

    state_e           state_q, state_d;
    logic [AW-1:0]    chunk_q, chunk_d;
    logic [CW-1:0]    n_q, n_d;
    logic [TW-1:0]    run_q, run_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] op_a_q [8], op_a_d [8], op_b_q [8], op_b_d [8];
    logic [RW-1:0]    res_q [4], res_d [4], sum [4];
    logic             clr, add, last, bad;

    assign last = CW'(chunk_q) == n_q - CW'(1);
    assign bad  = num_chunks == '0 || num_chunks > CW'(MAX_CHUNKS);

    // job sequencing: fetch, load, run the array, gap, accumulate, present
    always_comb begin
        state_d = state_q;
        chunk_d = chunk_q;
        n_d     = n_q;
        run_d   = '0;
        err_d   = err_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        res_d   = res_q;
        clr     = 1'b0;
        add     = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                err_d   = bad;
                clr     = 1'b1;
                chunk_d = '0;
                n_d     = num_chunks;
                state_d = bad ? OUT : FETCH;
            end
            FETCH: state_d = LOAD;
            LOAD: begin
                for (int i = 0; i < 8; i++) begin
                    op_a_d[i] = a_rd_data[i*WIDTH +: WIDTH];
                    op_b_d[i] = b_rd_data[i*WIDTH +: WIDTH];
                end
                state_d = RUN;
            end
            RUN: if (arr_done) begin
                res_d[0] = arr_result0;
                res_d[1] = arr_result1;
                res_d[2] = arr_result2;
                res_d[3] = arr_result3;
                state_d  = GAP;
            end else if (run_q == TW'(RUN_TIMEOUT - 1)) begin
                err_d   = 1'b1;
                state_d = OUT;
            end else begin
                run_d = run_q + 1'b1;
            end
            GAP: state_d = ACCUM;
            ACCUM: begin
                add     = 1'b1;
                state_d = last ? OUT : FETCH;
                chunk_d = last ? chunk_q : chunk_q + 1'b1;
            end
            OUT: state_d = out_ready ? IDLE : OUT;
            default: state_d = IDLE;
        endcase
    end

    // control and operand registers
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state_q <= IDLE;
            chunk_q <= '0;
            n_q     <= '0;
            run_q   <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                op_a_q[i] <= '0;
                op_b_q[i] <= '0;
            end
            for (int i = 0; i < 4; i++) res_q[i] <= '0;
        end else begin
            state_q <= state_d;
            chunk_q <= chunk_d;
            n_q     <= n_d;
            run_q   <= run_d;
            err_q   <= err_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            res_q   <= res_d;
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_acc
        sat_accum #(.IW(RW), .AW(ACCW)) u_acc (
            .clk(clk), ._reset(_reset), .clr(clr), .add_en(add),
            .addend(res_q[g]), .sat_out(sum[g])
        );
    end

`ifdef SYSARRAY_FEEDER_IMPORTANCE_EN
    logic [RW-1:0] imp_q, imp_d;
    // importance is only meaningful for the final chunk's array pass
    always_comb imp_d = clr ? '0 : (state_q == RUN && arr_done && last) ? arr_importance : imp_q;
    // importance capture register
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) imp_q <= '0;
        else         imp_q <= imp_d;
    end
    assign arr_cal_importance = state_q == RUN && last;
    assign out_importance     = imp_q;
`else
    logic unused_imp;
    assign unused_imp         = ^arr_importance;
    assign arr_cal_importance = 1'b0;
`endif

    assign rd_en      = state_q == FETCH;
    assign rd_addr    = chunk_q;
    assign arr_enable = state_q == RUN;
    assign out_valid  = state_q == OUT;
    assign busy       = state_q != IDLE;
    assign err        = err_q;
    assign {arr_a03, arr_a02, arr_a01, arr_a00} = {op_a_q[3], op_a_q[2], op_a_q[1], op_a_q[0]};
    assign {arr_a13, arr_a12, arr_a11, arr_a10} = {op_a_q[7], op_a_q[6], op_a_q[5], op_a_q[4]};
    assign {arr_b11, arr_b10, arr_b01, arr_b00} = {op_b_q[3], op_b_q[2], op_b_q[1], op_b_q[0]};
    assign {arr_b31, arr_b30, arr_b21, arr_b20} = {op_b_q[7], op_b_q[6], op_b_q[5], op_b_q[4]};
    assign {out_c00, out_c01, out_c10, out_c11} = {sum[0], sum[1], sum[2], sum[3]};
endmodule

// File: tb/tb_sysarray_tile_feeder.sv
// tb_sysarray_tile_feeder: random and directed jobs against a dot-product reference
module tb_sysarray_tile_feeder;
    logic        clk = 1'b0;
    logic        rst_n, start, out_ready, hang;
    logic [4:0]  num_chunks;
    logic        rd_en;
    logic [3:0]  rd_addr;
    logic [63:0] a_rd_data = '0, b_rd_data = '0;
    logic [7:0]  arr_a00, arr_a01, arr_a02, arr_a03, arr_a10, arr_a11, arr_a12, arr_a13;
    logic [7:0]  arr_b00, arr_b01, arr_b10, arr_b11, arr_b20, arr_b21, arr_b30, arr_b31;
    logic        arr_enable, arr_cal_importance, arr_done;
    logic [15:0] arr_result0, arr_result1, arr_result2, arr_result3;
    logic [15:0] arr_importance = 16'h1234;
    logic        out_valid, busy, err;
    logic [15:0] out_c00, out_c01, out_c10, out_c11;
    logic [63:0] av, bv;
    logic [63:0] mem_a [16], mem_b [16];
    logic signed [15:0] oc [4];
    int          acnt = 0, en_tot = 0, checks = 0, errors = 0;
`ifdef SYSARRAY_FEEDER_IMPORTANCE_EN
    logic [15:0] out_importance;
`endif

    sysarray_tile_feeder dut (
        .clk(clk), ._reset(rst_n), .start(start), .num_chunks(num_chunks),
        .rd_en(rd_en), .rd_addr(rd_addr), .a_rd_data(a_rd_data), .b_rd_data(b_rd_data),
        .arr_a00(arr_a00), .arr_a01(arr_a01), .arr_a02(arr_a02), .arr_a03(arr_a03),
        .arr_a10(arr_a10), .arr_a11(arr_a11), .arr_a12(arr_a12), .arr_a13(arr_a13),
        .arr_b00(arr_b00), .arr_b01(arr_b01), .arr_b10(arr_b10), .arr_b11(arr_b11),
        .arr_b20(arr_b20), .arr_b21(arr_b21), .arr_b30(arr_b30), .arr_b31(arr_b31),
        .arr_enable(arr_enable), .arr_cal_importance(arr_cal_importance), .arr_done(arr_done),
        .arr_result0(arr_result0), .arr_result1(arr_result1),
        .arr_result2(arr_result2), .arr_result3(arr_result3), .arr_importance(arr_importance),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_c00(out_c00), .out_c01(out_c01), .out_c10(out_c10), .out_c11(out_c11),
        .busy(busy), .err(err)
`ifdef SYSARRAY_FEEDER_IMPORTANCE_EN
        , .out_importance(out_importance)
`endif
    );

    always #5 clk = ~clk;

    function automatic int sat16(input int x);
        return x > 32767 ? 32767 : x < -32768 ? -32768 : x;
    endfunction

    function automatic int el(input logic [63:0] v, input int i);
        logic signed [7:0] t;
        t = v[i*8 +: 8];
        return int'(t);
    endfunction

    // element (r,c) of A(2x4) * B(4x2); A packed row-major, B packed k-major
    function automatic int dot(input logic [63:0] a, input logic [63:0] b, input int r, input int c);
        int d = 0;
        for (int k = 0; k < 4; k++) d += el(a, r*4 + k) * el(b, k*2 + c);
        return sat16(d);
    endfunction

    // operand bank: data one cycle after the read request
    always @(posedge clk) if (rd_en) begin
        a_rd_data <= mem_a[rd_addr];
        b_rd_data <= mem_b[rd_addr];
    end

    // mini array: done on the 5th enabled cycle, unless hung
    always @(posedge clk) begin
        acnt <= arr_enable ? acnt + 1 : 0;
        if (arr_enable) en_tot <= en_tot + 1;
    end
    assign arr_done = arr_enable && acnt == 4 && !hang;
    assign av = {arr_a13, arr_a12, arr_a11, arr_a10, arr_a03, arr_a02, arr_a01, arr_a00};
    assign bv = {arr_b31, arr_b30, arr_b21, arr_b20, arr_b11, arr_b10, arr_b01, arr_b00};
    assign arr_result0 = 16'(dot(av, bv, 0, 0));
    assign arr_result1 = 16'(dot(av, bv, 0, 1));
    assign arr_result2 = 16'(dot(av, bv, 1, 0));
    assign arr_result3 = 16'(dot(av, bv, 1, 1));
    assign oc[0] = out_c00;
    assign oc[1] = out_c01;
    assign oc[2] = out_c10;
    assign oc[3] = out_c11;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, $signed(got), $signed(exp));
        end
    endtask

    task automatic run_job(input int n, input string tag);
        int cyc, base;
        int e [4];
        bit bad;
        bad = n < 1 || n > 16;
        for (int i = 0; i < 4; i++) e[i] = 0;
        if (!bad && !hang)
            for (int c = 0; c < n; c++)
                for (int i = 0; i < 4; i++) e[i] += dot(mem_a[c], mem_b[c], i / 2, i % 2);
        for (int i = 0; i < 4; i++) e[i] = sat16(e[i]);
        @(negedge clk);
        start = 1'b1;
        num_chunks = 5'(n);
        base = en_tot;
        @(negedge clk);
        start = 1'b0;
        num_chunks = 5'($urandom);
        chk({tag, " busy"}, 32'(busy), 1);
        chk({tag, " err_at_start"}, 32'(err), 32'(bad));
        cyc = 0;
        while (!out_valid && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, " latency"}, cyc, bad ? 0 : hang ? 10 : 9 * n);
        chk({tag, " err"}, 32'(err), 32'(bad || hang));
        for (int i = 0; i < 4; i++) chk({tag, " out_c"}, 32'(oc[i]), e[i]);
        chk({tag, " arr_enable_off"}, 32'(arr_enable), 0);
        if (hang) chk({tag, " run_cycles"}, en_tot - base, 8);
        @(negedge clk);
        chk({tag, " hold_valid"}, 32'(out_valid), 1);
        chk({tag, " hold_c00"}, 32'(oc[0]), e[0]);
        out_ready = 1'b1;
        start = 1'b1;
        num_chunks = 5'd1;
        @(negedge clk);
        out_ready = 1'b0;
        start = 1'b0;
        chk({tag, " idle_after"}, 32'(busy), 0);
        chk({tag, " valid_after"}, 32'(out_valid), 0);
    endtask

    task automatic fill(input logic [63:0] a, input logic [63:0] b, input bit rnd);
        for (int c = 0; c < 16; c++) begin
            mem_a[c] = rnd ? {$urandom, $urandom} : a;
            mem_b[c] = rnd ? {$urandom, $urandom} : b;
        end
    endtask

    initial begin
        int cyc, seen;
        rst_n = 1'b0;
        start = 1'b0;
        out_ready = 1'b0;
        hang = 1'b0;
        num_chunks = '0;
        fill('0, '0, 1'b0);
        repeat (3) @(negedge clk);
        chk("rst busy", 32'(busy), 0);
        chk("rst out_valid", 32'(out_valid), 0);
        chk("rst err", 32'(err), 0);
        chk("rst arr_enable", 32'(arr_enable), 0);
        chk("rst rd_en", 32'(rd_en), 0);
        chk("rst cal_imp", 32'(arr_cal_importance), 0);
        chk("rst out_c00", 32'(oc[0]), 0);
        chk("rst arr_a00", 32'(arr_a00), 0);
        rst_n = 1'b1;
        fill({8{8'd1}}, {8{8'd2}}, 1'b0);
        run_job(1, "one_chunk");
        run_job(3, "three_chunk");
        fill({8{8'd127}}, {8{8'd127}}, 1'b0);
        run_job(16, "saturate");
        run_job(0, "zero_chunks");
        run_job(20, "too_many");
        fill('0, '0, 1'b1);
        run_job(2, "err_clear");
        hang = 1'b1;
        run_job(2, "timeout");
        hang = 1'b0;
        @(negedge clk);
        start = 1'b1;
        num_chunks = 5'd3;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!(rd_en && rd_addr == 4'd2) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        while (!arr_enable && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("mid_rst reached_chunk2", 32'(cyc < 200), 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst busy", 32'(busy), 0);
        chk("mid_rst arr_enable", 32'(arr_enable), 0);
        chk("mid_rst out_valid", 32'(out_valid), 0);
        chk("mid_rst out_c00", 32'(oc[0]), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid || busy) seen++;
        end
        chk("mid_rst no_output", seen, 0);
        run_job(3, "after_rst");
        for (int j = 0; j < 6; j++) begin
            fill('0, '0, 1'b1);
            run_job(int'($urandom_range(1, 16)), "random");
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
